// File: rtl/spec_path_history_if.sv
// Predict / resolve / retire / flush bundle for the speculative path-history register.
// The predictor front end is the master; the history block is the slave.
interface spec_path_history_if #(
  parameter int HIST_W     = 12,
  parameter int CKPT_DEPTH = 8,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
);
  logic              pred_valid;
  logic              pred_taken;
  logic              pred_ready;
  logic [TAG_W-1:0]  pred_tag;
  logic              resolve_valid;
  logic [TAG_W-1:0]  resolve_tag;
  logic              resolve_mispredict;
  logic              resolve_taken;
  logic              retire_valid;
  logic              flush;
  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] commit_hist;
  logic [TAG_W:0]    occupancy;

  modport master (
    output pred_valid, pred_taken, resolve_valid, resolve_tag, resolve_mispredict,
           resolve_taken, retire_valid, flush,
    input  pred_ready, pred_tag, hist, commit_hist, occupancy
  );

  modport slave (
    input  pred_valid, pred_taken, resolve_valid, resolve_tag, resolve_mispredict,
           resolve_taken, retire_valid, flush,
    output pred_ready, pred_tag, hist, commit_hist, occupancy
  );
endinterface

// File: rtl/spec_path_history.sv
// Speculative path-history register with one checkpoint per in-flight branch,
// single-cycle mispredict repair and an in-order committed history.
module spec_path_history #(
  parameter int HIST_W     = 12,
  parameter int CKPT_DEPTH = 8,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  spec_path_history_if.slave bus
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(CKPT_DEPTH);

  logic [HIST_W-1:0]     r_hist;
  logic [HIST_W-1:0]     r_commit_hist;
  logic [TAG_W-1:0]      r_head;
  logic [TAG_W-1:0]      r_tail;
  logic [TAG_W:0]        r_occ;
  logic [CKPT_DEPTH-1:0] r_live;
  logic [CKPT_DEPTH-1:0] r_resolved;
  logic [CKPT_DEPTH-1:0] r_outcome;
  logic [HIST_W-1:0]     r_ckpt_hist [CKPT_DEPTH];

  logic                  w_mis_req;
  logic                  w_ready;
  logic                  w_acc;
  logic                  w_res_ok;
  logic                  w_mis;
  logic                  w_ret;
  logic [TAG_W-1:0]      w_mis_dist;
  logic [TAG_W:0]        w_occ_mis;
  logic [CKPT_DEPTH-1:0] w_younger;

  function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h, input logic b);
    return {b, h[HIST_W-1:1]};
  endfunction

  // Any mispredict request blocks accept, even one that targets a dead tag.
  assign w_mis_req = bus.resolve_valid & bus.resolve_mispredict;
  assign w_ready   = (r_occ != FULL) & ~bus.flush & ~w_mis_req;
  assign w_acc     = bus.pred_valid & w_ready;
  assign w_res_ok  = bus.resolve_valid & r_live[bus.resolve_tag] &
                     ~r_resolved[bus.resolve_tag] & ~bus.flush;
  assign w_mis     = w_res_ok & bus.resolve_mispredict;
  assign w_ret     = bus.retire_valid & r_live[r_head] & r_resolved[r_head] & ~bus.flush;

  // Age is distance from head, so wrap-around needs no special casing.
  assign w_mis_dist = bus.resolve_tag - r_head;
  assign w_occ_mis  = {1'b0, w_mis_dist} + (TAG_W+1)'(1) - (TAG_W+1)'(w_ret);

  always_comb begin
    w_younger = '0;
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      w_younger[i] = (TAG_W'(i) - r_head) > w_mis_dist;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist        <= '0;
      r_commit_hist <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_occ         <= '0;
      r_live        <= '0;
      r_resolved    <= '0;
    end else if (bus.flush) begin
      r_hist <= r_commit_hist;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_live <= '0;
    end else begin
      if (w_mis) begin
        r_hist <= shift_in(r_ckpt_hist[bus.resolve_tag], bus.resolve_taken);
        r_tail <= bus.resolve_tag + TAG_W'(1);
        r_occ  <= w_occ_mis;
      end else begin
        if (w_acc) begin
          r_hist <= shift_in(r_hist, bus.pred_taken);
          r_tail <= r_tail + TAG_W'(1);
        end
        r_occ <= r_occ + (TAG_W+1)'(w_acc) - (TAG_W+1)'(w_ret);
      end

      if (w_ret) begin
        r_commit_hist <= shift_in(r_commit_hist, r_outcome[r_head]);
        r_head        <= r_head + TAG_W'(1);
      end

      for (int i = 0; i < CKPT_DEPTH; i++) begin
        if (w_acc && (r_tail == TAG_W'(i))) begin
          r_live[i]     <= 1'b1;
          r_resolved[i] <= 1'b0;
        end
        if (w_res_ok && (bus.resolve_tag == TAG_W'(i))) begin
          r_resolved[i] <= 1'b1;
        end
        if ((w_mis && w_younger[i]) || (w_ret && (r_head == TAG_W'(i)))) begin
          r_live[i] <= 1'b0;
        end
      end
    end
  end

  // Checkpoint payload is only meaningful while its slot is live, so it carries no reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_acc) begin
        r_ckpt_hist[r_tail] <= r_hist;
        r_outcome[r_tail]   <= bus.pred_taken;
      end
      if (w_mis) begin
        r_outcome[bus.resolve_tag] <= bus.resolve_taken;
      end
    end
  end

  assign bus.pred_ready  = w_ready;
  assign bus.pred_tag    = r_tail;
  assign bus.hist        = r_hist;
  assign bus.commit_hist = r_commit_hist;
  assign bus.occupancy   = r_occ;

endmodule

// File: tb/tb_spec_path_history.sv
// Directed scoreboard bench for spec_path_history (HIST_W=12, CKPT_DEPTH=4).
module tb_spec_path_history;

  logic clock = 1'b0;
  logic reset = 1'b1;

  spec_path_history_if #(.HIST_W(12), .CKPT_DEPTH(4), .TAG_W(2)) ifc ();

  spec_path_history #(.HIST_W(12), .CKPT_DEPTH(4), .TAG_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] actual(input string n);
    case (n)
      "hist":   return {4'b0, ifc.hist};
      "commit": return {4'b0, ifc.commit_hist};
      "occ":    return {13'b0, ifc.occupancy};
      "ready":  return {15'b0, ifc.pred_ready};
      "tag":    return {14'b0, ifc.pred_tag};
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic push(input string n, input logic [15:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [15:0] a;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      a = actual(x.name);
      checks++;
      assert (a === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", x.name, a, x.exp);
      end
    end
  endtask

  // Combinational outputs for the inputs currently driven.
  task automatic chk_now();
    #1;
    drain();
  endtask

  // Advance one clock and compare registered outputs just after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
    drain();
  endtask

  task automatic idle();
    ifc.pred_valid         = 1'b0;
    ifc.pred_taken         = 1'b0;
    ifc.resolve_valid      = 1'b0;
    ifc.resolve_tag        = 2'd0;
    ifc.resolve_mispredict = 1'b0;
    ifc.resolve_taken      = 1'b0;
    ifc.retire_valid       = 1'b0;
    ifc.flush              = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    push("hist", 16'h000); push("commit", 16'h000);
    push("occ", 16'd0);    push("ready", 16'd1);
    chk_now();
  endtask

  task automatic accept(input logic t, input logic [15:0] e_tag, input logic [15:0] e_hist);
    idle();
    ifc.pred_valid = 1'b1;
    ifc.pred_taken = t;
    push("ready", 16'd1); push("tag", e_tag);
    chk_now();
    push("hist", e_hist);
    cyc();
    idle();
  endtask

  task automatic resolve_ok(input logic [1:0] tg);
    idle();
    ifc.resolve_valid = 1'b1;
    ifc.resolve_tag   = tg;
    cyc();
    idle();
  endtask

  task automatic scen2();
    accept(1'b1, 16'd0, 16'h800);
    accept(1'b1, 16'd1, 16'hC00);
    accept(1'b0, 16'd2, 16'h600);
    push("occ", 16'd3);
    chk_now();
  endtask

  initial begin
    idle();

    // Scenario 1: reset
    do_reset();

    // Scenario 2/3: fill then overflow attempt
    scen2();
    accept(1'b1, 16'd3, 16'hB00);
    push("occ", 16'd4); push("ready", 16'd0);
    chk_now();
    ifc.pred_valid = 1'b1;
    ifc.pred_taken = 1'b1;
    push("ready", 16'd0);
    chk_now();
    push("hist", 16'hB00); push("occ", 16'd4); push("tag", 16'd0);
    cyc();
    idle();

    // Scenario 4: mispredict tag1 not-taken, with a competing prediction
    do_reset();
    scen2();
    ifc.resolve_valid      = 1'b1;
    ifc.resolve_tag        = 2'd1;
    ifc.resolve_mispredict = 1'b1;
    ifc.resolve_taken      = 1'b0;
    ifc.pred_valid         = 1'b1;
    ifc.pred_taken         = 1'b1;
    push("ready", 16'd0);
    chk_now();
    push("hist", 16'h400); push("occ", 16'd2);
    cyc();
    idle();
    push("tag", 16'd2); push("ready", 16'd1);
    chk_now();

    // Scenario 5: retire rules
    ifc.retire_valid = 1'b1;
    push("occ", 16'd2); push("commit", 16'h000); push("hist", 16'h400);
    cyc();
    resolve_ok(2'd0);
    ifc.retire_valid = 1'b1;
    push("commit", 16'h800); push("occ", 16'd1);
    cyc();
    resolve_ok(2'd1);
    ifc.retire_valid = 1'b1;
    push("commit", 16'h400); push("occ", 16'd0);
    cyc();
    idle();

    // Mispredict on a dead tag changes nothing
    ifc.resolve_valid      = 1'b1;
    ifc.resolve_tag        = 2'd3;
    ifc.resolve_mispredict = 1'b1;
    ifc.resolve_taken      = 1'b1;
    push("hist", 16'h400); push("occ", 16'd0); push("tag", 16'd2);
    cyc();
    idle();

    // Scenario 6: flush with same-cycle predict and retire
    do_reset();
    accept(1'b1, 16'd0, 16'h800);
    accept(1'b0, 16'd1, 16'h400);
    resolve_ok(2'd0);
    ifc.retire_valid = 1'b1;
    push("commit", 16'h800); push("occ", 16'd1);
    cyc();
    idle();
    accept(1'b1, 16'd2, 16'hA00);
    resolve_ok(2'd1);
    push("occ", 16'd2); push("commit", 16'h800);
    chk_now();
    ifc.flush        = 1'b1;
    ifc.pred_valid   = 1'b1;
    ifc.pred_taken   = 1'b1;
    ifc.retire_valid = 1'b1;
    push("ready", 16'd0);
    chk_now();
    push("hist", 16'h800); push("occ", 16'd0); push("commit", 16'h800); push("tag", 16'd0);
    cyc();
    idle();
    push("ready", 16'd1);
    chk_now();
    accept(1'b1, 16'd0, 16'hC00);
    push("occ", 16'd1);
    chk_now();

    // Reset mid-stream with a prediction pending
    reset          = 1'b1;
    ifc.pred_valid = 1'b1;
    ifc.pred_taken = 1'b1;
    push("hist", 16'h000); push("commit", 16'h000); push("occ", 16'd0); push("tag", 16'd0);
    cyc();
    reset = 1'b0;
    idle();
    push("ready", 16'd1);
    chk_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
